// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: state encoding,
// starvation counter width and default bus widths.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned DataWDefault = 32;
  localparam int unsigned StarveW      = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StBusyIf  = 3'd1,
    StBusyMem = 3'd2,
    StDoneIf  = 3'd3,
    StDoneMem = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating starvation counter: counts MEM grants made while IF waits and
// flags when the limit is reached so IF can be forced through.
`timescale 1ns/1ps
module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam logic [StarveW-1:0] LimitVal = StarveW'(Limit);

  logic [StarveW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LimitVal)) begin
      cnt_d = cnt_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LimitVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. One
// transaction at a time; MEM wins unless IF has been starved STARVE_LIMIT times.
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddrWDefault,
  parameter int unsigned DATA_W       = DataWDefault,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IFReq,
  input  logic [ADDR_W-1:0] IFAddr,
  output logic [DATA_W-1:0] IFData,
  output logic              IFReady,
  input  logic              MEMRead,
  input  logic              MEMWrite,
  input  logic [ADDR_W-1:0] MEMAddr,
  input  logic [DATA_W-1:0] MEMWData,
  output logic [DATA_W-1:0] MEMRData,
  output logic              MEMReady,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData
);

  arb_state_e        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              ctr_inc, ctr_clr, starve_hit;

  mem_arb_starve_ctr #(
    .Limit (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .inc_i  (ctr_inc),
    .clr_i  (ctr_clr),
    .hit_o  (starve_hit)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ctr_inc     = 1'b0;
    ctr_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A write wins over a simultaneous read, so MEMWrite alone sets the direction.
        if ((MEMRead || MEMWrite) && !(IFReq && starve_hit)) begin
          state_d     = StBusyMem;
          mem_we_d    = MEMWrite;
          mem_addr_d  = MEMAddr;
          mem_wdata_d = MEMWData;
          ctr_inc     = IFReq;
        end else if (IFReq) begin
          state_d    = StBusyIf;
          mem_we_d   = 1'b0;
          mem_addr_d = IFAddr;
          ctr_clr    = 1'b1;
        end
      end
      StBusyIf: begin
        if (MemAck) begin
          if_data_d = MemRData;
          state_d   = StDoneIf;
        end
      end
      StBusyMem: begin
        if (MemAck) begin
          if (!mem_we_q) begin
            mem_rdata_d = MemRData;
          end
          state_d = StDoneMem;
        end
      end
      StDoneIf, StDoneMem: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign MemReq   = (state_q == StBusyIf) || (state_q == StBusyMem);
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign IFReady  = (state_q == StDoneIf);
  assign MEMReady = (state_q == StDoneMem);
  assign IFData   = if_data_q;
  assign MEMRData = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected memory-side requests and
// Ready completions are queued as stimulus is driven and checked on arrival.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          IFReq;
  logic [AW-1:0] IFAddr;
  logic [DW-1:0] IFData;
  logic          IFReady;
  logic          MEMRead;
  logic          MEMWrite;
  logic [AW-1:0] MEMAddr;
  logic [DW-1:0] MEMWData;
  logic [DW-1:0] MEMRData;
  logic          MEMReady;
  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic          MemAck;
  logic [DW-1:0] MemRData;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .IFReq    (IFReq),
    .IFAddr   (IFAddr),
    .IFData   (IFData),
    .IFReady  (IFReady),
    .MEMRead  (MEMRead),
    .MEMWrite (MEMWrite),
    .MEMAddr  (MEMAddr),
    .MEMWData (MEMWData),
    .MEMRData (MEMRData),
    .MEMReady (MEMReady),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemAck   (MemAck),
    .MemRData (MemRData)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic          is_if;
    logic [DW-1:0] data;
  } rdy_exp_t;

  mem_exp_t exp_mem[$];
  rdy_exp_t exp_rdy[$];

  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] model_mem_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_mem(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.wdata = wd;
    exp_mem.push_back(m);
  endtask

  task automatic expect_rdy(input logic is_if, input logic [DW-1:0] data);
    rdy_exp_t r;
    r.is_if = is_if; r.data = data;
    exp_rdy.push_back(r);
  endtask

  // Acts as the memory: waits for MemReq, acks after 'delay' cycles, checks Ready.
  task automatic serve(input int delay, input logic [DW-1:0] rdata,
                       output int waited, output int unsigned rdy_cyc);
    mem_exp_t m;
    rdy_exp_t r;
    int hi;
    waited  = 0;
    rdy_cyc = 0;
    while (MemReq !== 1'b1 && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    if (MemReq !== 1'b1) begin
      check("memreq_timeout", 32'(MemReq), 32'd1);
      return;
    end
    if (exp_mem.size() == 0 || exp_rdy.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    m = exp_mem.pop_front();
    check("memwe", 32'(MemWe), 32'(m.we));
    check("memaddr", MemAddr, m.addr);
    if (m.we) check("memwdata", MemWData, m.wdata);
    hi = 1;
    repeat (delay) begin
      @(negedge Clk);
      if (MemReq === 1'b1) hi++;
    end
    MemAck   = 1'b1;
    MemRData = rdata;
    @(negedge Clk);
    MemAck   = 1'b0;
    MemRData = 32'hDEAD_0000;
    check("memreq_high_cycles", 32'(hi), 32'(delay + 1));
    check("memreq_drop", 32'(MemReq), 32'd0);
    r = exp_rdy.pop_front();
    check("ifready", 32'(IFReady), 32'(r.is_if));
    check("memready", 32'(MEMReady), 32'(!r.is_if));
    if (r.is_if) check("ifdata", IFData, r.data);
    else check("memrdata", MEMRData, r.data);
    rdy_cyc = cyc;
    @(negedge Clk);
    check("ready_one_pulse", {30'd0, IFReady, MEMReady}, 32'd0);
  endtask

  initial begin
    int w;
    int unsigned c1, c2;
    Reset_n  = 1'b0;
    IFReq    = 1'b0; IFAddr  = '0;
    MEMRead  = 1'b0; MEMWrite = 1'b0; MEMAddr = '0; MEMWData = '0;
    MemAck   = 1'b0; MemRData = '0;
    model_mem_rdata = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_memwe", 32'(MemWe), 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_memwdata", MemWData, 32'd0);
    check("rst_ifdata", IFData, 32'd0);
    check("rst_memrdata", MEMRData, 32'd0);
    check("rst_ready", {30'd0, IFReady, MEMReady}, 32'd0);

    // Async reset in the middle of a MEM transaction.
    MEMWrite = 1'b1; MEMAddr = 32'h20; MEMWData = 32'h5555_5555;
    @(negedge Clk);
    check("midrst_busy", 32'(MemReq), 32'd1);
    MemAck = 1'b1; MemRData = 32'h7777_7777;
    #1 Reset_n = 1'b0;
    #1;
    check("midrst_memreq", 32'(MemReq), 32'd0);
    check("midrst_memwe", 32'(MemWe), 32'd0);
    check("midrst_memaddr", MemAddr, 32'd0);
    check("midrst_memwdata", MemWData, 32'd0);
    MEMWrite = 1'b0; MEMAddr = '0; MEMWData = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    MemAck = 1'b0;
    check("postrst_memreq", 32'(MemReq), 32'd0);
    check("postrst_ready", {30'd0, IFReady, MEMReady}, 32'd0);
    check("postrst_memrdata", MEMRData, 32'd0);
    @(negedge Clk);
    check("postrst_idle", 32'(MemReq), 32'd0);

    // Store with a two-cycle ack delay.
    MEMWrite = 1'b1; MEMAddr = 32'h4; MEMWData = 32'hBEEF_BEEF;
    expect_mem(1'b1, 32'h4, 32'hBEEF_BEEF);
    expect_rdy(1'b0, model_mem_rdata);
    serve(2, 32'h1234_5678, w, c1);
    MEMWrite = 1'b0;

    // Load with immediate ack: MemReq the cycle after the request is sampled.
    MEMRead = 1'b1; MEMAddr = 32'h4;
    model_mem_rdata = 32'hBEEF_BEEF;
    expect_mem(1'b0, 32'h4, '0);
    expect_rdy(1'b0, model_mem_rdata);
    serve(0, 32'hBEEF_BEEF, w, c1);
    check("load_latency", 32'(w), 32'd1);
    MEMRead = 1'b0;

    // Simultaneous IF and MEM requests with the counter at zero.
    IFReq = 1'b1; IFAddr = 32'h200; MEMRead = 1'b1; MEMAddr = 32'h10;
    model_mem_rdata = 32'hA5A5_0010;
    expect_mem(1'b0, 32'h10, '0);
    expect_rdy(1'b0, model_mem_rdata);
    expect_mem(1'b0, 32'h200, '0);
    expect_rdy(1'b1, 32'h1111_2222);
    serve(0, 32'hA5A5_0010, w, c1);
    MEMRead = 1'b0;
    serve(0, 32'h1111_2222, w, c2);
    IFReq = 1'b0;
    check("if_after_mem_gap", c2 - c1, 32'd3);

    // Starvation: MEM held continuously, IF must get through after SL MEM grants.
    IFReq = 1'b1; IFAddr = 32'h100; MEMRead = 1'b1; MEMAddr = 32'h40;
    for (int i = 0; i < SL; i++) begin
      expect_mem(1'b0, 32'h40, '0);
      expect_rdy(1'b0, 32'h3000_0000 + 32'(i));
    end
    expect_mem(1'b0, 32'h100, '0);
    expect_rdy(1'b1, 32'h2002_0001);
    for (int i = 0; i < SL; i++) serve(0, 32'h3000_0000 + 32'(i), w, c1);
    model_mem_rdata = 32'h3000_0000 + 32'(SL - 1);
    serve(0, 32'h2002_0001, w, c2);
    IFReq = 1'b0; MEMRead = 1'b0;

    // Counter cleared by the IF grant: MEM wins the next tie again.
    IFReq = 1'b1; IFAddr = 32'h104; MEMRead = 1'b1; MEMAddr = 32'h44;
    model_mem_rdata = 32'h4444_0000;
    expect_mem(1'b0, 32'h44, '0);
    expect_rdy(1'b0, model_mem_rdata);
    expect_mem(1'b0, 32'h104, '0);
    expect_rdy(1'b1, 32'h2002_0002);
    serve(1, 32'h4444_0000, w, c1);
    MEMRead = 1'b0;
    serve(0, 32'h2002_0002, w, c2);
    IFReq = 1'b0;

    // Read and write together: treated as a write, MEMRData untouched.
    MEMRead = 1'b1; MEMWrite = 1'b1; MEMAddr = 32'h8; MEMWData = 32'hCAFE_F00D;
    expect_mem(1'b1, 32'h8, 32'hCAFE_F00D);
    expect_rdy(1'b0, model_mem_rdata);
    serve(1, 32'h0BAD_0BAD, w, c1);
    MEMRead = 1'b0; MEMWrite = 1'b0;

    @(negedge Clk);
    check("final_idle", 32'(MemReq), 32'd0);
    check("sb_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("sb_rdy_drained", 32'(exp_rdy.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data/instruction memory port between the IF stage (fetch) and the MEM stage (load/store) of the pipeline.
- Serialises one transaction at a time and holds the memory-side request until the memory acknowledges, so memory latency may vary per access.
- Gives each requester a one-cycle Ready pulse; a requester with no Ready stalls its pipeline stage.
- MEM has priority by default; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive MEM grants while IF waits before IF is forced through (legal 1..15)

Ports:
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- IFReq  in  1  fetch request, level; held until IFReady
- IFAddr  in  ADDR_W  fetch address
- IFData  out  DATA_W  fetched word, valid when IFReady=1
- IFReady  out  1  one-cycle completion pulse to IF
- MEMRead  in  1  load request, level; held until MEMReady
- MEMWrite  in  1  store request, level; held until MEMReady
- MEMAddr  in  ADDR_W  load/store address (ALU result)
- MEMWData  in  DATA_W  store data
- MEMRData  out  DATA_W  load data, valid when MEMReady=1
- MEMReady  out  1  one-cycle completion pulse to MEM
- MemReq  out  1  memory request, held until MemAck
- MemWe  out  1  1=write, 0=read; stable while MemReq=1
- MemAddr  out  ADDR_W  registered address
- MemWData  out  DATA_W  registered write data
- MemAck  in  1  memory done; read data valid in same cycle
- MemRData  in  DATA_W  memory read data

Behaviour:
- Reset (async, Reset_n=0): state IDLE; MemReq, MemWe, IFReady, MEMReady = 0; MemAddr, MemWData, IFData, MEMRData = 0; starve counter = 0. Outputs drop immediately, even mid-transaction. A pending MemAck after reset is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- IDLE: sample requests at the clock edge.
  - Grant MEM if (MEMRead|MEMWrite) and not (IFReq and starve counter == STARVE_LIMIT); otherwise grant IF if IFReq.
  - On grant, latch address/data/we into Mem* registers and go to the matching BUSY state.
  - With no request, stay in IDLE.
- MEMRead and MEMWrite both high: treated as a write; the read is ignored.
- BUSY_x: MemReq=1. On MemAck=1:
  - For IF, or for a MEM read, register MemRData into IFData/MEMRData.
  - Go to DONE_x; MemReq deasserts on the following cycle.
- DONE_x: the matching Ready=1 for exactly one cycle, then IDLE. IDLE samples new requests in that next cycle, so back-to-back transactions have one IDLE cycle between them.
- Minimum latency: request seen at edge N → MemReq in cycle N+1 → (ack in N+1) → Ready in cycle N+2.
- IFData/MEMRData hold their last value between transactions. A MEM write leaves MEMRData unchanged.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each MEM grant made while IFReq=1.
  - Clears to 0 on each IF grant.
  - Unchanged on a MEM grant with IFReq=0.
- Request withdrawn mid-transaction: ignored. The transaction completes and Ready still pulses.
- Request inputs change while BUSY: ignored, since the Mem* registers are latched.
- Long MemAck delay: no timeout. The arbiter waits indefinitely.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants (3-bit, IDLE=0)
  - starve-counter width constant (4)
  - ADDR_W/DATA_W defaults
- One sub-module: mem_arb_starve_ctr (saturating counter with inc/clr/limit-hit output), instantiated once.
- FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- Reset: Reset_n=0 mid-BUSY_MEM with MemReq=1 → MemReq=0 with no clock edge; after release, IDLE, all outputs 0.
- Store: MEMWrite=1, MEMAddr=4, MEMWData=0xBEEF_BEEF, MemAck 2 cycles after MemReq rises → MemWe=1, MemAddr=4, MemWData=0xBEEF_BEEF, MemReq high 3 cycles, MEMReady one pulse; MEMRData unchanged.
- Load: MEMRead=1, MEMAddr=4, memory returns 0xBEEF_BEEF with immediate ack → MEMReady at edge+2, MEMRData=0xBEEF_BEEF, MemWe=0.
- Simultaneous: IFReq and MEMRead asserted in the same cycle, counter=0 → MEM served first, IF next; IFReady follows MEMReady by 3 cycles with single-cycle acks.
- Starvation (STARVE_LIMIT=4): IFReq held while MEMRead is re-asserted continuously → exactly 4 MEM grants, then an IF grant (IFAddr=0x100, IFData=0x2002_0001); counter returns to 0.
- Both MEMRead and MEMWrite = 1, MEMAddr=8 → write issued (MemWe=1), one MEMReady pulse, MEMRData unchanged.
